// File: rtl/cpu_pkg.sv
// Shared ISA definitions for the decode stage: opcodes, PC-select codes,
// control-word layout, ALU operation codes and the opcode decoder.
package cpu_pkg;

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_SUB  = 6'd1;
    localparam logic [5:0] OP_AND  = 6'd2;
    localparam logic [5:0] OP_OR   = 6'd3;
    localparam logic [5:0] OP_ADDI = 6'd4;
    localparam logic [5:0] OP_SUBI = 6'd5;
    localparam logic [5:0] OP_ANDI = 6'd6;
    localparam logic [5:0] OP_ORI  = 6'd7;
    localparam logic [5:0] OP_LW   = 6'd8;
    localparam logic [5:0] OP_SW   = 6'd9;
    localparam logic [5:0] OP_BEQ  = 6'd10;
    localparam logic [5:0] OP_BNE  = 6'd11;
    localparam logic [5:0] OP_J    = 6'd12;
    localparam logic [5:0] OP_JR   = 6'd13;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_NEXT = 2'b00,
        PC_OFFS = 2'b01,
        PC_REG  = 2'b10
    } pcsrc_e;

    localparam int CTRL_W        = 8;
    localparam int CTRL_REGWR    = 7;
    localparam int CTRL_MEMRD    = 6;
    localparam int CTRL_MEMWR    = 5;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_ALUOP_LSB = 0;
    localparam int ALUOP_W       = 4;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_OR  = 4'h3;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic              use_rs;
        logic              use_rt;
        logic              is_beq;
        logic              is_bne;
        logic              is_j;
        logic              is_jr;
    } dec_t;

    // Maps an opcode to its control word and the register sources it reads.
    function automatic dec_t decode_op(input logic [5:0] op);
        dec_t d;
        d = '0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                d.ctrl[CTRL_REGWR] = 1'b1;
                d.ctrl[CTRL_ALUOP_LSB +: ALUOP_W] = {2'b00, op[1:0]};
                d.use_rs = 1'b1;
                d.use_rt = 1'b1;
            end
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: begin
                d.ctrl[CTRL_REGWR]  = 1'b1;
                d.ctrl[CTRL_ALUSRC] = 1'b1;
                d.ctrl[CTRL_ALUOP_LSB +: ALUOP_W] = {2'b00, op[1:0]};
                d.use_rs = 1'b1;
            end
            OP_LW: begin
                d.ctrl[CTRL_REGWR]  = 1'b1;
                d.ctrl[CTRL_MEMRD]  = 1'b1;
                d.ctrl[CTRL_ALUSRC] = 1'b1;
                d.ctrl[CTRL_ALUOP_LSB +: ALUOP_W] = ALU_ADD;
                d.use_rs = 1'b1;
            end
            OP_SW: begin
                d.ctrl[CTRL_MEMWR]  = 1'b1;
                d.ctrl[CTRL_ALUSRC] = 1'b1;
                d.ctrl[CTRL_ALUOP_LSB +: ALUOP_W] = ALU_ADD;
                d.use_rs = 1'b1;
                d.use_rt = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                d.ctrl[CTRL_ALUOP_LSB +: ALUOP_W] = ALU_SUB;
                d.use_rs = 1'b1;
                d.use_rt = 1'b1;
                d.is_beq = (op == OP_BEQ);
                d.is_bne = (op == OP_BNE);
            end
            OP_J: begin
                d.is_j = 1'b1;
            end
            OP_JR: begin
                d.use_rs = 1'b1;
                d.is_jr  = 1'b1;
            end
            default: begin
                d = '0;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/reg_file.sv
// 16x32 register file, two async read ports and one write port, R0 reads zero
// and a same-cycle write is bypassed to the read ports.
module reg_file #(
    parameter int NREGS = 16,
    parameter int XLEN  = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   ra_a,
    input  logic [AW-1:0]   ra_b,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] rd_a,
    output logic [XLEN-1:0] rd_b
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] ra);
        if (ra == '0) begin
            return '0;
        end
        if (we && (wa == ra)) begin
            return wd;
        end
        return regs[ra];
    endfunction

    assign rd_a = read_port(ra_a);
    assign rd_b = read_port(ra_b);

endmodule

// File: rtl/id_stage.sv
// Decode stage: register read with MEM/WB forwarding, hazard stalls, branch/jump
// resolution and IF redirect. Optional stall counter under ID_STALL_CNT_EN.
module id_stage
    import cpu_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     Instruction_D,
    input  logic [XLEN-1:0] NPC_D,
    input  logic            RegWr_E,
    input  logic            MemRd_E,
    input  logic [3:0]      Rd_E,
    input  logic            RegWr_M,
    input  logic            RegWr_W,
    input  logic [3:0]      Rd_M,
    input  logic [3:0]      Rd_W,
    input  logic [XLEN-1:0] Fwd_M,
    input  logic [XLEN-1:0] Wdata_W,
    output logic [XLEN-1:0] A_D,
    output logic [XLEN-1:0] B_D,
    output logic [XLEN-1:0] Imm_D,
    output logic [3:0]      Rd_D,
    output logic [7:0]      Ctrl_D,
    output logic            bubble,
    output logic            disable_PC,
    output logic            disable_IR,
    output logic            KILL,
    output logic [1:0]      PCsrc,
    output logic [XLEN-1:0] PC_offset,
    output logic [XLEN-1:0] PC_regRs,
    output logic [15:0]     stall_cnt
);

    logic [5:0]  opcode;
    logic [3:0]  rd, rs, rt;
    logic [13:0] imm14;
    logic [25:0] imm26;
    dec_t        dec;

    assign opcode = Instruction_D[31:26];
    assign rd     = Instruction_D[25:22];
    assign rs     = Instruction_D[21:18];
    assign rt     = Instruction_D[17:14];
    assign imm14  = Instruction_D[13:0];
    assign imm26  = Instruction_D[25:0];
    assign dec    = decode_op(opcode);

    logic [XLEN-1:0] rf_a, rf_b;

    reg_file #(.NREGS(NREGS), .XLEN(XLEN)) u_reg_file (
        .clk  (clk),
        .reset(reset),
        .ra_a (rs),
        .ra_b (rt),
        .we   (RegWr_W),
        .wa   (Rd_W),
        .wd   (Wdata_W),
        .rd_a (rf_a),
        .rd_b (rf_b)
    );

    // WB forwarding lives in the register file bypass; MEM takes priority here.
    function automatic logic [XLEN-1:0] fwd_mem(input logic [3:0] src,
                                                input logic [XLEN-1:0] rf_val);
        if (RegWr_M && (Rd_M == src) && (src != 4'd0)) begin
            return Fwd_M;
        end
        return rf_val;
    endfunction

    assign A_D = fwd_mem(rs, rf_a);
    assign B_D = fwd_mem(rt, rf_b);

    logic signed [XLEN-1:0] imm14_s, imm26_s;
    assign imm14_s = {{(XLEN-14){imm14[13]}}, imm14};
    assign imm26_s = {{(XLEN-26){imm26[25]}}, imm26};
    assign Imm_D   = imm14_s;

    logic src_hit_e, load_use, ctl_hazard, stall;
    assign src_hit_e  = (Rd_E != 4'd0) &&
                        ((dec.use_rs && (Rd_E == rs)) || (dec.use_rt && (Rd_E == rt)));
    assign load_use   = MemRd_E && src_hit_e;
    assign ctl_hazard = (dec.is_beq || dec.is_bne || dec.is_jr) && RegWr_E && src_hit_e;
    assign stall      = reset && (load_use || ctl_hazard);

    logic taken, go_offs, go_reg;
    assign taken   = (dec.is_beq && (A_D == B_D)) || (dec.is_bne && (A_D != B_D));
    assign go_offs = reset && !stall && (taken || dec.is_j);
    assign go_reg  = reset && !stall && dec.is_jr;

    assign PC_offset = NPC_D + $unsigned(dec.is_j ? imm26_s : imm14_s);
    assign PC_regRs  = A_D;

    always_comb begin
        PCsrc = PC_NEXT;
        if (go_offs) begin
            PCsrc = PC_OFFS;
        end else if (go_reg) begin
            PCsrc = PC_REG;
        end
    end

    assign KILL       = go_offs || go_reg;
    assign disable_PC = stall;
    assign disable_IR = stall;
    assign bubble     = stall;

    assign Ctrl_D = stall ? '0 : dec.ctrl;
    assign Rd_D   = (stall || !dec.ctrl[CTRL_REGWR]) ? 4'd0 : rd;

`ifdef ID_STALL_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (disable_PC) begin
            cnt <= sat_inc(cnt);
        end
    end

    assign stall_cnt = cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage with a behavioural model checked every cycle.
module tb_id_stage;
    import cpu_pkg::*;

    logic        clk, reset;
    logic [31:0] Instruction_D, NPC_D;
    logic        RegWr_E, MemRd_E, RegWr_M, RegWr_W;
    logic [3:0]  Rd_E, Rd_M, Rd_W;
    logic [31:0] Fwd_M, Wdata_W;
    logic [31:0] A_D, B_D, Imm_D, PC_offset, PC_regRs;
    logic [3:0]  Rd_D;
    logic [7:0]  Ctrl_D;
    logic        bubble, disable_PC, disable_IR, KILL;
    logic [1:0]  PCsrc;
    logic [15:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    logic [31:0] mreg [16];
    logic        m_stall = 1'b0;
    logic [15:0] m_cnt = 16'd0;

    id_stage dut (
        .clk(clk), .reset(reset), .Instruction_D(Instruction_D), .NPC_D(NPC_D),
        .RegWr_E(RegWr_E), .MemRd_E(MemRd_E), .Rd_E(Rd_E),
        .RegWr_M(RegWr_M), .RegWr_W(RegWr_W), .Rd_M(Rd_M), .Rd_W(Rd_W),
        .Fwd_M(Fwd_M), .Wdata_W(Wdata_W), .A_D(A_D), .B_D(B_D), .Imm_D(Imm_D),
        .Rd_D(Rd_D), .Ctrl_D(Ctrl_D), .bubble(bubble), .disable_PC(disable_PC),
        .disable_IR(disable_IR), .KILL(KILL), .PCsrc(PCsrc),
        .PC_offset(PC_offset), .PC_regRs(PC_regRs), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ins(input logic [5:0] op, input logic [3:0] d,
                                        input logic [3:0] s, input logic [3:0] t,
                                        input logic [13:0] imm);
        return {op, d, s, t, imm};
    endfunction

    function automatic logic [31:0] jins(input logic [5:0] op, input logic [25:0] imm);
        return {op, imm};
    endfunction

    // Architectural register contents as seen by the decode stage.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) mreg[i] <= 32'd0;
        end else if (RegWr_W && (Rd_W != 4'd0)) begin
            mreg[Rd_W] <= Wdata_W;
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) m_cnt <= 16'd0;
        else if (m_stall && (m_cnt != 16'hFFFF)) m_cnt <= m_cnt + 16'd1;
    end

    function automatic logic [31:0] src_val(input logic [3:0] s);
        if (s == 4'd0) return 32'd0;
        if (RegWr_M && (Rd_M == s)) return Fwd_M;
        if (RegWr_W && (Rd_W == s)) return Wdata_W;
        return mreg[s];
    endfunction

    always @(negedge clk) begin : model_cmp
        logic [5:0]  op;
        logic [3:0]  f_rd, f_rs, f_rt, erd, aluop;
        logic [31:0] ea, eb, eimm, epco;
        logic        use_rs, use_rt, hit, haz, roff, rreg, regwr;
        logic [7:0]  ectrl;
        logic [1:0]  epc;
        logic [15:0] ecnt;

        op   = Instruction_D[31:26];
        f_rd = Instruction_D[25:22];
        f_rs = Instruction_D[21:18];
        f_rt = Instruction_D[17:14];
        ea   = src_val(f_rs);
        eb   = src_val(f_rt);
        eimm = {{18{Instruction_D[13]}}, Instruction_D[13:0]};
        epco = (op == 6'd12) ? NPC_D + {{6{Instruction_D[25]}}, Instruction_D[25:0]}
                             : NPC_D + eimm;
        use_rs = (op <= 6'd11) || (op == 6'd13);
        use_rt = (op <= 6'd3) || ((op >= 6'd9) && (op <= 6'd11));
        hit = (Rd_E != 4'd0) && ((use_rs && (Rd_E == f_rs)) || (use_rt && (Rd_E == f_rt)));
        haz = hit && (MemRd_E ||
                      (RegWr_E && ((op == 6'd10) || (op == 6'd11) || (op == 6'd13))));
        haz = haz && reset;
        roff = reset && !haz && (((op == 6'd10) && (ea == eb)) ||
                                 ((op == 6'd11) && (ea != eb)) || (op == 6'd12));
        rreg = reset && !haz && (op == 6'd13);
        epc  = roff ? 2'b01 : (rreg ? 2'b10 : 2'b00);
        regwr = (op <= 6'd8);
        if (op <= 6'd7) aluop = {2'b00, op[1:0]};
        else if ((op == 6'd10) || (op == 6'd11)) aluop = 4'h1;
        else aluop = 4'h0;
        ectrl = {regwr, op == 6'd8, op == 6'd9, (op >= 6'd4) && (op <= 6'd9), aluop};
        erd   = regwr ? f_rd : 4'd0;
        if (haz) begin
            ectrl = 8'h00;
            erd   = 4'd0;
        end
        m_stall = haz;
`ifdef ID_STALL_CNT_EN
        ecnt = m_cnt;
`else
        ecnt = 16'd0;
`endif
        if (chk_en) begin
            chk("m_disable_PC", 32'(disable_PC), 32'(haz));
            chk("m_disable_IR", 32'(disable_IR), 32'(haz));
            chk("m_bubble", 32'(bubble), 32'(haz));
            chk("m_KILL", 32'(KILL), 32'(roff || rreg));
            chk("m_PCsrc", 32'(PCsrc), 32'(epc));
            chk("m_stall_cnt", 32'(stall_cnt), 32'(ecnt));
            if (reset) begin
                chk("m_A_D", A_D, ea);
                chk("m_B_D", B_D, eb);
                chk("m_Imm_D", Imm_D, eimm);
                chk("m_Rd_D", 32'(Rd_D), 32'(erd));
                chk("m_Ctrl_D", 32'(Ctrl_D), 32'(ectrl));
                chk("m_PC_offset", PC_offset, epco);
                chk("m_PC_regRs", PC_regRs, ea);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        Instruction_D = jins(OP_J, 26'd5);
        NPC_D = 32'd0;
        RegWr_E = 0; MemRd_E = 0; Rd_E = 0;
        RegWr_M = 0; Rd_M = 0; Fwd_M = 0;
        RegWr_W = 0; Rd_W = 0; Wdata_W = 0;
        #1 reset = 1'b0;
        chk_en = 1;
        at_neg();
        chk("rst_PCsrc", 32'(PCsrc), 32'd0);
        chk("rst_KILL", 32'(KILL), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        cyc();
        reset = 1'b1;
        Instruction_D = ins(OP_ADD, 4'd1, 4'd3, 4'd0, 14'd0);
        RegWr_W = 1; Rd_W = 4'd3; Wdata_W = 32'd7;
        at_neg();
        chk("rst_A_D_zero_bypass7", A_D, 32'd7);
        chk("add_ctrl", 32'(Ctrl_D), 32'h80);
        chk("add_rd", 32'(Rd_D), 32'd1);
        cyc();
        RegWr_W = 0;
        at_neg();
        chk("r3_written", A_D, 32'd7);

        // reset mid-run with a jump held at the input
        cyc();
        reset = 1'b0;
        Instruction_D = jins(OP_J, 26'd5);
        #1;
        chk("midrst_PCsrc", 32'(PCsrc), 32'd0);
        chk("midrst_KILL", 32'(KILL), 32'd0);
        chk("midrst_disable_PC", 32'(disable_PC), 32'd0);
        #2;
        reset = 1'b1;
        Instruction_D = ins(OP_ADD, 4'd1, 4'd3, 4'd0, 14'd0);
        at_neg();
        chk("midrst_r3_cleared", A_D, 32'd0);

        cyc();
        RegWr_W = 1; Rd_W = 4'd5; Wdata_W = 32'h1234;
        Instruction_D = ins(OP_ADD, 4'd1, 4'd5, 4'd0, 14'd0);
        at_neg();
        chk("wb_bypass", A_D, 32'h1234);
        cyc();
        Rd_W = 4'd0; Wdata_W = 32'hDEAD_BEEF;
        Instruction_D = ins(OP_ADD, 4'd1, 4'd0, 4'd5, 14'd0);
        at_neg();
        chk("r0_bypass_zero", A_D, 32'd0);
        chk("r5_read", B_D, 32'h1234);
        cyc();
        RegWr_W = 0;
        at_neg();
        chk("r0_still_zero", A_D, 32'd0);

        cyc();
        MemRd_E = 1; RegWr_E = 1; Rd_E = 4'd2;
        Instruction_D = ins(OP_ADD, 4'd3, 4'd2, 4'd0, 14'd0);
        at_neg();
        chk("lu_disable_PC", 32'(disable_PC), 32'd1);
        chk("lu_disable_IR", 32'(disable_IR), 32'd1);
        chk("lu_bubble", 32'(bubble), 32'd1);
        chk("lu_ctrl", 32'(Ctrl_D), 32'd0);
        cyc();
        MemRd_E = 0; RegWr_E = 0; Rd_E = 4'd0;
        at_neg();
        chk("lu_release", 32'(disable_PC), 32'd0);
        chk("lu_release_ctrl", 32'(Ctrl_D), 32'h80);
        chk("lu_release_rd", 32'(Rd_D), 32'd3);

        cyc();
        RegWr_W = 1; Rd_W = 4'd1; Wdata_W = 32'd9;
        Instruction_D = NOP_WORD;
        cyc();
        Rd_W = 4'd2;
        cyc();
        RegWr_W = 0;
        NPC_D = 32'd20;
        Instruction_D = ins(OP_BEQ, 4'd0, 4'd1, 4'd2, 14'h3FFC);
        at_neg();
        chk("beq_PCsrc", 32'(PCsrc), 32'd1);
        chk("beq_target", PC_offset, 32'd16);
        chk("beq_KILL", 32'(KILL), 32'd1);
        chk("beq_ctrl", 32'(Ctrl_D), 32'h01);
        cyc();
        RegWr_W = 1; Rd_W = 4'd2; Wdata_W = 32'd8;
        at_neg();
        chk("beq_nt_PCsrc", 32'(PCsrc), 32'd0);
        chk("beq_nt_KILL", 32'(KILL), 32'd0);
        cyc();
        RegWr_W = 0;
        Instruction_D = ins(OP_BNE, 4'd0, 4'd1, 4'd2, 14'h3FFC);
        at_neg();
        chk("bne_PCsrc", 32'(PCsrc), 32'd1);

        cyc();
        Instruction_D = ins(OP_ADD, 4'd1, 4'd6, 4'd6, 14'd0);
        RegWr_M = 1; Rd_M = 4'd6; Fwd_M = 32'hAAAA;
        RegWr_W = 1; Rd_W = 4'd6; Wdata_W = 32'hBBBB;
        at_neg();
        chk("mem_over_wb", A_D, 32'hAAAA);

        cyc();
        RegWr_W = 0; Rd_M = 4'd4; Fwd_M = 32'd100;
        Instruction_D = ins(OP_JR, 4'd0, 4'd4, 4'd0, 14'd0);
        at_neg();
        chk("jr_PCsrc", 32'(PCsrc), 32'd2);
        chk("jr_target", PC_regRs, 32'd100);
        chk("jr_KILL", 32'(KILL), 32'd1);
        cyc();
        RegWr_E = 1; Rd_E = 4'd4;
        at_neg();
        chk("jr_haz_stall", 32'(disable_PC), 32'd1);
        chk("jr_haz_KILL", 32'(KILL), 32'd0);
        chk("jr_haz_PCsrc", 32'(PCsrc), 32'd0);

        cyc();
        RegWr_E = 0; Rd_E = 4'd0; RegWr_M = 0;
        NPC_D = 32'hFFFF_FFFE;
        Instruction_D = jins(OP_J, 26'd3);
        at_neg();
        chk("j_wrap", PC_offset, 32'd1);
        chk("j_PCsrc", 32'(PCsrc), 32'd1);
        cyc();
        Instruction_D = ins(OP_SW, 4'd7, 4'd1, 4'd2, 14'd5);
        at_neg();
        chk("sw_ctrl", 32'(Ctrl_D), 32'h30);
        chk("sw_rd", 32'(Rd_D), 32'd0);
        cyc();
        Instruction_D = ins(6'd63, 4'd7, 4'd1, 4'd2, 14'd5);
        at_neg();
        chk("undef_ctrl", 32'(Ctrl_D), 32'd0);

        // stall counting from a fresh reset
        cyc();
        reset = 1'b0;
        #3;
        reset = 1'b1;
        MemRd_E = 1; RegWr_E = 1; Rd_E = 4'd2;
        Instruction_D = ins(OP_ADD, 4'd3, 4'd2, 4'd0, 14'd0);
        cyc();
        cyc();
        cyc();
        MemRd_E = 0; RegWr_E = 0; Rd_E = 4'd0;
        at_neg();
`ifdef ID_STALL_CNT_EN
        chk("stall_cnt_3", 32'(stall_cnt), 32'd3);
`else
        chk("stall_cnt_off", 32'(stall_cnt), 32'd0);
`endif
        cyc();
        cyc();
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
